forward_hazard_unit: RTL
========================

# forward_hazard_unit

Parametrised forwarding and load-use hazard unit for the in-order core. It tracks the destination registers of instructions in flight across `DEPTH` post-decode stages in an internal shift pipeline. For each decode-stage source operand it selects the youngest matching producer stage as the forwarding source. When the youngest producer is a load whose data is not yet available, it raises a one-or-more-cycle stall and inserts a bubble into EX.

## Interface
- `REG_ADDR_W`, 3: register address width; address 0 is hardwired zero.
- `NUM_SRC`, 2: number of decode source operands checked per cycle.
- `DEPTH`, 3: tracked stages after decode; stage 1 = EX, stage `DEPTH` = last stage before regfile write.
- `LOAD_LAT`, 2: first stage index at which load data is forwardable; 1 ≤ `LOAD_LAT` ≤ `DEPTH`.
- `CNT_W`, 16: stall counter width.
- Derived: `FWD_W = $clog2(DEPTH+1)`.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `issue_valid_i` in 1: the decode instruction is presented for issue into EX this cycle.
- `issue_rd_addr_i` in `REG_ADDR_W`: destination of the decode instruction.
- `issue_we_i` in 1: the decode instruction writes `rd`.
- `issue_is_load_i` in 1: the decode instruction is a load.
- `flush_i` in 1: the decode instruction is discarded this cycle.
- `rs_addr_i` in `NUM_SRC`×`REG_ADDR_W`: source addresses of the decode instruction, packed, source 0 in LSBs.
- `rs_used_i` in `NUM_SRC`: the source is actually read.
- `forward_o` out `NUM_SRC`×`FWD_W`: per-source select; 0 = regfile, k = stage k.
- `stall_o` out 1: hold fetch/decode; bubble goes to EX.
- `stall_count_o` out `CNT_W`: saturating count of stalled cycles.

## Operation
- The internal pipe holds `DEPTH` entries of {valid, we, is_load, rd}. Every cycle, entry k moves to k+1 and entry `DEPTH` retires.
- Entry 1 load, in priority order:
  - Bubble (valid=0) if `flush_i`, `stall_o` or `!issue_valid_i`.
  - Otherwise {1, `issue_we_i`, `issue_is_load_i`, `issue_rd_addr_i`}.
- A match for source s in stage k requires valid & we & rd≠0 & rd==`rs_addr_i[s]` & `rs_used_i[s]`.
- If several stages match, the lowest k (youngest) wins.
- Per-source result:
  - Winning stage is a load with k < `LOAD_LAT`: hazard[s]=1, `forward_o[s]`=0.
  - Winning stage otherwise: `forward_o[s]`=k, hazard[s]=0.
  - No match: `forward_o[s]`=0, hazard[s]=0.
- `stall_o` = `issue_valid_i` & !`flush_i` & OR(hazard).
- `stall_count_o` increments by 1 on every cycle with `stall_o`=1 and holds at all-ones.
- With the defaults, a load immediately followed by a dependent instruction gives exactly 1 stall cycle, then `forward_o`=2.

## Timing
- `forward_o` and `stall_o` are combinational from the inputs and registered pipe state, with zero-cycle latency. The pipe and counter update on the rising edge.
- While `rst_ni`=0 at an edge, all pipe entries are cleared to invalid and `stall_count_o` is cleared to 0.
- After reset, all `forward_o`=0 and `stall_o`=0 until issues arrive. Reset mid-operation discards all in-flight entries, with no residual forwarding on the next cycle.
- During a stall, the pipe keeps advancing, so the hazard resolves by itself after `LOAD_LAT`−k cycles. A stall never lasts longer than `LOAD_LAT`−1 consecutive cycles.
- `flush_i` together with a hazard: no stall, and a bubble is inserted.
- `rs_used_i[s]`=0 or `rs_addr_i[s]`=0: never forwards and never stalls for that source.
- A producer retiring from stage `DEPTH` in the same cycle is still forwarded from `DEPTH`; on the next cycle the regfile (select 0) is used. The regfile is write-before-read.

## Structure
- Package `hazard_pkg` contains:
  - `stage_entry_t` struct {valid, we, is_load, rd} with `REG_ADDR_W` as a package parameter.
  - Constant `FWD_REGFILE`=0.
- Sub-module `hazard_stage_pipe` implements the `DEPTH`-entry shift register with bubble insertion and synchronous reset, and exposes all entries.
- The top level holds the per-source priority match (generate loop over `NUM_SRC`), the stall logic and the counter.

## Test plan
- Reset held 2 cycles with random inputs, then released with `issue_valid_i`=0: `forward_o`=0, `stall_o`=0, `stall_count_o`=0.
- Issue ALU writing x3, then an instruction reading rs1=x3, rs2=x3: `forward_o`={1,1}; one cycle later, an instruction reading x3 gives 2; then 3; then 0.
- Issue a load to x5, then a reader of x5: `stall_o`=1 for 1 cycle and `stall_count_o`=1; the next cycle `stall_o`=0 and `forward_o[0]`=2.
- Issue ALU writes to x4 in two consecutive cycles, then read x4: select 1 (youngest). With rd=x0 producers, reads of x0 give 0.
- Load-use hazard with `flush_i`=1 in the same cycle: `stall_o`=0, and a bubble is seen (no forwarding from stage 1 next cycle).
- Preload `stall_count_o` near saturation via repeated load-use pairs (with `CNT_W`=4): the count holds at 15. Reset mid-sequence clears the pipe and the counter.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the forwarding/hazard unit
package hazard_pkg;

  parameter int REG_ADDR_W = 3;

  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rd;
  } stage_entry_t;

endpackage

// File: rtl/hazard_stage_pipe.sv
// rtl/hazard_stage_pipe.sv - DEPTH-entry shift pipe of in-flight destinations
module hazard_stage_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     insert,
  input  stage_entry_t             entry,
  output stage_entry_t [DEPTH-1:0] stages
);

  // stages[0] is EX; the pipe advances every cycle, stalls included
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stages <= '0;
    end else begin
      stages[0] <= insert ? entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        stages[k] <= stages[k-1];
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - operand forwarding select and load-use stall
module forward_hazard_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          issue_valid_i,
  input  logic [REG_ADDR_W-1:0]         issue_rd_addr_i,
  input  logic                          issue_we_i,
  input  logic                          issue_is_load_i,
  input  logic                          flush_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_addr_i,
  input  logic [NUM_SRC-1:0]            rs_used_i,
  output logic [NUM_SRC*FWD_W-1:0]      forward_o,
  output logic                          stall_o,
  output logic [CNT_W-1:0]              stall_count_o
);

  import hazard_pkg::*;

  stage_entry_t [DEPTH-1:0] stages;
  stage_entry_t             issue_entry;
  logic [NUM_SRC-1:0]       hazard;
  logic                     insert;
  logic [CNT_W-1:0]         stall_count;

  assign issue_entry = '{valid: 1'b1, we: issue_we_i, is_load: issue_is_load_i, rd: issue_rd_addr_i};
  assign insert      = issue_valid_i & ~flush_i & ~stall_o;

  hazard_stage_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .insert (insert),
    .entry  (issue_entry),
    .stages (stages)
  );

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic [FWD_W-1:0]      sel;
    logic                  haz;
    logic                  found;

    assign rs = rs_addr_i[s*REG_ADDR_W +: REG_ADDR_W];

    // scan from EX outward so the youngest producer wins
    always_comb begin
      sel   = FWD_W'(FWD_REGFILE);
      haz   = 1'b0;
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && rs_used_i[s] && stages[k].valid && stages[k].we &&
            stages[k].rd != '0 && stages[k].rd == rs) begin
          found = 1'b1;
          if (stages[k].is_load && (k + 1) < LOAD_LAT) begin
            haz = 1'b1;
          end else begin
            sel = FWD_W'(k + 1);
          end
        end
      end
    end

    assign forward_o[s*FWD_W +: FWD_W] = sel;
    assign hazard[s] = haz;
  end

  assign stall_o = issue_valid_i & ~flush_i & (|hazard);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_count <= '0;
    end else if (stall_o && stall_count != '1) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign stall_count_o = stall_count;

endmodule
